// File: rtl/systolic_array_seq.sv
// Pass sequencer for an N x N systolic MAC array: weight preload, skewed
// activation streaming, result drain and a one-cycle done pulse.
module systolic_array_seq #(
    parameter int unsigned N      = 4,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned CNT_W  = 9
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [7:0]             k_len,
    input  logic                   stall,
    input  logic                   abort,
    output logic                   busy,
    output logic                   done,
    output logic                   pe_enable,
    output logic                   weight_load,
    output logic                   accumulate,
    output logic                   w_rd_en,
    output logic [ADDR_W-1:0]      w_rd_addr,
    output logic                   a_rd_en,
    output logic [ADDR_W-1:0]      a_rd_addr,
    output logic [N-1:0]           row_valid,
    output logic                   res_valid,
    output logic [$clog2(N)-1:0]   res_row
);

    localparam int unsigned ROW_W = $clog2(N);
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         klen_q, klen_d;

    logic [CNT_W-1:0]   klen_ext;
    logic [CNT_W-1:0]   stream_last;
    logic               in_busy_state;
    logic               advance;

    assign klen_ext      = CNT_W'(klen_q);
    assign stream_last   = klen_ext + CNT_W'(N - 2);
    assign in_busy_state = (state_q == S_LOAD_W) || (state_q == S_STREAM) ||
                           (state_q == S_DRAIN);
    assign advance       = !stall;

    // State, phase counter and latched vector count
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            klen_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            klen_q  <= klen_d;
        end
    end

    // Next-state: abort beats stall; stall freezes state and counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        klen_d  = klen_q;
        if (in_busy_state && abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        cnt_d = '0;
                        if (k_len != 8'd0) begin
                            state_d = S_LOAD_W;
                            klen_d  = k_len;
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end
                S_LOAD_W: begin
                    if (advance) begin
                        if (cnt_q == LAST_ROW) begin
                            state_d = S_STREAM;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                S_STREAM: begin
                    if (advance) begin
                        if (cnt_q == stream_last) begin
                            state_d = S_DRAIN;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (advance) begin
                        if (cnt_q == LAST_ROW) begin
                            state_d = S_DONE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Moore output decode; stall gates every strobe but leaves busy/accumulate
    always_comb begin
        busy        = 1'b0;
        done        = 1'b0;
        pe_enable   = 1'b0;
        weight_load = 1'b0;
        accumulate  = 1'b0;
        w_rd_en     = 1'b0;
        w_rd_addr   = '0;
        a_rd_en     = 1'b0;
        a_rd_addr   = '0;
        row_valid   = '0;
        res_valid   = 1'b0;
        res_row     = '0;
        case (state_q)
            S_LOAD_W: begin
                busy        = 1'b1;
                pe_enable   = advance;
                weight_load = advance;
                w_rd_en     = advance;
                w_rd_addr   = ADDR_W'(cnt_q);
            end
            S_STREAM: begin
                busy       = 1'b1;
                accumulate = 1'b1;
                pe_enable  = advance;
                if (cnt_q < klen_ext) begin
                    a_rd_en   = advance;
                    a_rd_addr = ADDR_W'(cnt_q);
                end
                // Row i sees its K vectors delayed by i cycles
                for (int unsigned i = 0; i < N; i++) begin
                    row_valid[i] = advance && (cnt_q >= CNT_W'(i)) &&
                                   (cnt_q < klen_ext + CNT_W'(i));
                end
            end
            S_DRAIN: begin
                busy       = 1'b1;
                accumulate = 1'b1;
                pe_enable  = advance;
                res_valid  = advance;
                res_row    = ROW_W'(cnt_q);
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_systolic_array_seq.sv
// Scoreboard bench for systolic_array_seq (N=4): expected per-cycle output
// snapshots are queued by the driver and checked by an independent monitor.
module tb_systolic_array_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  k_len;
    logic        stall;
    logic        abort;
    logic        busy;
    logic        done;
    logic        pe_enable;
    logic        weight_load;
    logic        accumulate;
    logic        w_rd_en;
    logic [7:0]  w_rd_addr;
    logic        a_rd_en;
    logic [7:0]  a_rd_addr;
    logic [3:0]  row_valid;
    logic        res_valid;
    logic [1:0]  res_row;

    systolic_array_seq #(.N(4), .ADDR_W(8), .CNT_W(9)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .k_len       (k_len),
        .stall       (stall),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .pe_enable   (pe_enable),
        .weight_load (weight_load),
        .accumulate  (accumulate),
        .w_rd_en     (w_rd_en),
        .w_rd_addr   (w_rd_addr),
        .a_rd_en     (a_rd_en),
        .a_rd_addr   (a_rd_addr),
        .row_valid   (row_valid),
        .res_valid   (res_valid),
        .res_row     (res_row)
    );

    typedef struct {
        int          cyc;
        logic [29:0] v;
    } exp_t;

    exp_t        sb[$];
    logic [29:0] nrm [16];
    logic [29:0] stall_v;
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Snapshot layout: {busy,done,pe,wl,acc,w_en,a_en,res_v,row_valid,w_addr,a_addr,res_row}
    function automatic logic [29:0] v(logic b, logic d, logic pe, logic wl, logic acc,
                                      logic wen, int wa, logic aen, int aa,
                                      logic [3:0] rv, logic rsv, int rr);
        return {b, d, pe, wl, acc, wen, aen, rsv, rv, 8'(wa), 8'(aa), 2'(rr)};
    endfunction

    function automatic logic [29:0] pack_out();
        return {busy, done, pe_enable, weight_load, accumulate, w_rd_en, a_rd_en,
                res_valid, row_valid,
                (w_rd_en   ? w_rd_addr : 8'h00),
                (a_rd_en   ? a_rd_addr : 8'h00),
                (res_valid ? res_row   : 2'b00)};
    endfunction

    task automatic push(input int c, input logic [29:0] val);
        exp_t e;
        e.cyc = c;
        e.v   = val;
        sb.push_back(e);
    endtask

    task automatic go(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_normal(input int base);
        for (int o = 1; o <= 15; o++) push(base + o, nrm[o]);
    endtask

    // Monitor: compare whenever the DUT is busy/done or an expectation is due
    initial begin : monitor
        logic [29:0] act;
        exp_t        e;
        forever begin
            @(negedge clk);
            act = pack_out();
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                tests++;
                fails++;
                $display("FAIL missed_cycle cyc=%0d expected=%h never compared", sb[0].cyc, sb[0].v);
                void'(sb.pop_front());
            end
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                tests++;
                if (act !== e.v) begin
                    fails++;
                    $display("FAIL outputs cyc=%0d actual=%h expected=%h", cyc, act, e.v);
                end
            end else if (busy === 1'b1 || done === 1'b1) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output cyc=%0d actual=%h expected idle", cyc, act);
            end
        end
    end

    initial begin : driver
        int c;
        rst   = 1'b1;
        start = 1'b0;
        k_len = 8'd0;
        stall = 1'b0;
        abort = 1'b0;

        // Hand-derived K=3, N=4 pass, indexed by cycles after the start cycle
        for (int o = 1; o <= 4; o++) nrm[o] = v(1,0,1,1,0,1, o-1, 0,0, 4'b0000, 0,0);
        nrm[5]  = v(1,0,1,0,1,0,0, 1,0, 4'b0001, 0,0);
        nrm[6]  = v(1,0,1,0,1,0,0, 1,1, 4'b0011, 0,0);
        nrm[7]  = v(1,0,1,0,1,0,0, 1,2, 4'b0111, 0,0);
        nrm[8]  = v(1,0,1,0,1,0,0, 0,0, 4'b1110, 0,0);
        nrm[9]  = v(1,0,1,0,1,0,0, 0,0, 4'b1100, 0,0);
        nrm[10] = v(1,0,1,0,1,0,0, 0,0, 4'b1000, 0,0);
        for (int o = 11; o <= 14; o++) nrm[o] = v(1,0,1,0,1,0,0, 0,0, 4'b0000, 1, o-11);
        nrm[15] = v(0,1,0,0,0,0,0, 0,0, 4'b0000, 0,0);
        nrm[0]  = '0;
        stall_v = v(1,0,0,0,1,0,0, 0,0, 4'b0000, 0,0);

        // Reset state
        push(1, '0);
        push(2, '0);
        push(3, '0);
        go(3);
        rst = 1'b0;

        // Plain pass, K=3
        go(5);
        c = cyc;
        start = 1'b1;
        k_len = 8'd3;
        push_normal(c);
        go(c + 1);
        start = 1'b0;
        go(c + 17);

        // Two stall cycles at STREAM cnt=1
        c = cyc;
        start = 1'b1;
        for (int o = 1; o <= 5; o++) push(c + o, nrm[o]);
        push(c + 6, stall_v);
        push(c + 7, stall_v);
        for (int o = 6; o <= 15; o++) push(c + o + 2, nrm[o]);
        go(c + 1);
        start = 1'b0;
        go(c + 6);
        stall = 1'b1;
        go(c + 8);
        stall = 1'b0;
        go(c + 19);

        // Abort at DRAIN cnt=2, then a fresh pass
        c = cyc;
        start = 1'b1;
        for (int o = 1; o <= 13; o++) push(c + o, nrm[o]);
        push(c + 14, '0);
        push_normal(c + 15);
        go(c + 1);
        start = 1'b0;
        go(c + 13);
        abort = 1'b1;
        go(c + 14);
        abort = 1'b0;
        go(c + 15);
        start = 1'b1;
        go(c + 16);
        start = 1'b0;
        go(c + 32);

        // Empty pass: done only, no reads
        c = cyc;
        start = 1'b1;
        k_len = 8'd0;
        push(c + 1, v(0,1,0,0,0,0,0, 0,0, 4'b0000, 0,0));
        push(c + 2, '0);
        go(c + 1);
        start = 1'b0;
        k_len = 8'd3;
        go(c + 4);

        // Start pulse during STREAM must be ignored
        c = cyc;
        start = 1'b1;
        push_normal(c);
        go(c + 1);
        start = 1'b0;
        go(c + 7);
        start = 1'b1;
        go(c + 8);
        start = 1'b0;
        go(c + 20);

        // Reset mid-LOAD_W with start held high
        c = cyc;
        start = 1'b1;
        k_len = 8'd3;
        push(c + 1, nrm[1]);
        push(c + 2, nrm[2]);
        push(c + 3, '0);
        push_normal(c + 3);
        go(c + 2);
        rst = 1'b1;
        go(c + 3);
        rst = 1'b0;
        go(c + 4);
        start = 1'b0;
        go(c + 22);

        while (sb.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL leftover cyc=%0d expected=%h not observed", sb[0].cyc, sb[0].v);
            void'(sb.pop_front());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/systolic_array_seq.md
Name: systolic_array_seq

Overview:
- Sequencer for an N x N grid of systolic MAC processing elements.
- On one start command it runs a full matrix-multiply pass:
  - weight preload,
  - skewed activation streaming over k_len vectors,
  - pipeline drain,
  - a one-cycle done.
- Drives the PE control lines (enable, weight_load, accumulate), the weight/activation buffer read ports and the per-row injection mask.
- Sits between the CPU's accelerator command register and the PE array.

Parameters:
- N, 4, array dimension (rows = columns); N >= 2.
- ADDR_W, 8, width of weight/activation buffer read addresses.
- CNT_W, 9, width of the internal phase counter; must hold 255 + N - 1.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a pass; sampled only in IDLE
- k_len  in  8  number of activation vectors for this pass; latched on accepted start
- stall  in  1  buffer not ready; freezes sequencing
- abort  in  1  cancel current pass
- busy  out  1  high in LOAD_W, STREAM, DRAIN
- done  out  1  one-cycle pulse at end of pass
- pe_enable  out  1  PE enable
- weight_load  out  1  PE weight-load strobe
- accumulate  out  1  PE accumulate mode
- w_rd_en  out  1  weight buffer read enable
- w_rd_addr  out  ADDR_W  weight row address
- a_rd_en  out  1  activation buffer read enable
- a_rd_addr  out  ADDR_W  activation vector address
- row_valid  out  N  per-row skewed injection mask
- res_valid  out  1  result row available at array bottom
- res_row  out  $clog2(N)  index of result row being drained

Behaviour:
- Moore machine. State and counter cnt are registered; all outputs decode combinationally from state/cnt/stall.
- Reset (synchronous):
  - state = IDLE, cnt = 0, latched k_len = 0.
  - Every output is 0.
- States: IDLE, LOAD_W, STREAM, DRAIN, DONE.
- IDLE:
  - start=1 with k_len>0 → LOAD_W next cycle; latch k_len; cnt=0.
  - start=1 with k_len=0 → DONE next cycle (empty pass, no buffer reads).
- LOAD_W, cnt 0..N-1:
  - pe_enable = weight_load = w_rd_en = 1.
  - w_rd_addr = cnt; accumulate = 0.
  - At cnt=N-1 → STREAM, cnt=0.
- STREAM, cnt 0..k_len+N-2:
  - pe_enable = accumulate = 1.
  - a_rd_en = 1 while cnt < k_len; a_rd_addr = cnt, otherwise 0.
  - row_valid[i] = 1 iff i <= cnt < k_len + i (diagonal skew).
  - At last count → DRAIN, cnt=0.
- DRAIN, cnt 0..N-1:
  - pe_enable = accumulate = res_valid = 1.
  - res_row = cnt; row_valid = 0.
  - At cnt=N-1 → DONE.
- DONE:
  - done = 1 for exactly one cycle; busy = 0.
  - → IDLE.
- busy = 1 exactly in LOAD_W, STREAM, DRAIN.
- Stall (stall=1 in LOAD_W/STREAM/DRAIN):
  - state and cnt hold.
  - pe_enable, weight_load, w_rd_en, a_rd_en, res_valid and row_valid are all forced to 0.
  - busy stays 1.
  - accumulate keeps its state value.
  - stall is ignored in IDLE/DONE.
- Abort:
  - abort=1 in any busy state → IDLE next cycle, cnt=0, no done pulse.
  - abort has priority over stall.
  - abort in IDLE/DONE has no effect (DONE still pulses).
- start outside IDLE is ignored; start coincident with abort in IDLE is accepted.
- Latency without stalls, k_len = K: start accepted at cycle 0; LOAD_W cycles 1..N; STREAM N+1..2N+K-1; DRAIN 2N+K..3N+K-1; done at 3N+K.
- Addresses zero-extend to ADDR_W; an ADDR_W smaller than 8 truncates (configuration error, not checked).

Test Plan:
- N=4, start with k_len=3:
  - weight_load and w_rd_en high cycles 1-4, w_rd_addr 0,1,2,3.
  - STREAM cycles 5-10; a_rd_addr 0,1,2 on cycles 5-7.
  - row_valid 0001,0011,0111,1110,1100,1000.
  - res_valid cycles 11-14 with res_row 0-3; done pulse cycle 15.
- Same pass with stall=1 for 2 cycles at STREAM cnt=1:
  - all enables and row_valid are 0 during the stall; cnt holds.
  - the row_valid sequence resumes unchanged.
  - done shifts to cycle 17.
- abort asserted at DRAIN cnt=2:
  - next cycle state is IDLE, busy=0, no done.
  - a new start one cycle later runs a full normal pass.
- start with k_len=0 → done pulse one cycle later; busy, w_rd_en and a_rd_en never assert.
- start pulsed during STREAM is ignored: exactly one done pulse.
- rst asserted mid-LOAD_W → next cycle all outputs 0, state IDLE; the held start is accepted the cycle after rst deasserts.
